// File: rtl/pe_pkg.sv
// Shared definitions for the Processing Element dot-product datapath.
// Holds the default widths, the signed accumulator/output types and the two
// arithmetic helpers (saturating add, round/shift/saturate requantiser) so
// that RTL and any reference model agree on the exact arithmetic.
package pe_pkg;

    localparam int W_Y        = 18;   // partial-sum width from vec_mul
    localparam int W_ACC      = 32;   // accumulator width
    localparam int W_OUT      = 16;   // requantised output width
    localparam int MAX_CHUNKS = 256;  // max partial sums per result
    localparam int W_CNT      = $clog2(MAX_CHUNKS + 1);
    localparam int W_SHIFT    = 5;

    typedef logic signed [W_ACC-1:0] acc_t;
    typedef logic signed [W_OUT-1:0] out_t;

    typedef struct packed {
        acc_t val;
        logic ovf;
    } acc_sat_t;

    typedef struct packed {
        out_t val;
        logic sat;
    } rq_t;

    localparam acc_t ACC_MAX = {1'b0, {(W_ACC-1){1'b1}}};
    localparam acc_t ACC_MIN = {1'b1, {(W_ACC-1){1'b0}}};

    // a + b clamped to the acc_t range; ovf flags a clamp.
    function automatic acc_sat_t sat_add(input acc_t a, input acc_t b);
        logic signed [W_ACC:0] s;
        acc_sat_t              res;
        s = {a[W_ACC-1], a} + {b[W_ACC-1], b};
        // The top two bits disagree exactly when the true sum left the acc_t range.
        if (s[W_ACC] != s[W_ACC-1]) begin
            res.ovf = 1'b1;
            res.val = s[W_ACC] ? ACC_MIN : ACC_MAX;
        end else begin
            res.ovf = 1'b0;
            res.val = s[W_ACC-1:0];
        end
        return res;
    endfunction

    // Round half up, arithmetic shift right, saturate to out_t.
    function automatic rq_t requant(input acc_t a, input logic [W_SHIFT-1:0] shift);
        logic signed [W_ACC:0] ext;
        logic signed [W_ACC:0] half;
        logic signed [W_ACC:0] rounded;
        logic signed [W_ACC:0] r;
        logic signed [W_ACC:0] hi;
        logic signed [W_ACC:0] lo;
        rq_t                   res;
        ext = {a[W_ACC-1], a};
        if (shift == '0) begin
            half    = '0;
            rounded = ext;
            r       = ext;
        end else begin
            // One extra bit keeps the rounding add from wrapping at ACC_MAX.
            half    = (W_ACC+1)'(1) << (shift - 5'd1);
            rounded = ext + half;
            r       = rounded >>> shift;
        end
        hi = (W_ACC+1)'((1 << (W_OUT-1)) - 1);
        lo = ~hi;
        if (r > hi) begin
            res.val = {1'b0, {(W_OUT-1){1'b1}}};
            res.sat = 1'b1;
        end else if (r < lo) begin
            res.val = {1'b1, {(W_OUT-1){1'b0}}};
            res.sat = 1'b1;
        end else begin
            res.val = r[W_OUT-1:0];
            res.sat = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/pe_requant.sv
// Combinational requantiser: rounds half up, shifts right arithmetically by
// i_shift (0 = pass-through) and saturates to the output width.
// Ports:
//   i_acc    signed accumulated value
//   i_shift  right-shift amount
//   o_data   signed requantised value
//   o_clip   1 when the value was clipped to the output range
module pe_requant
    import pe_pkg::*;
(
    input  acc_t               i_acc,
    input  logic [W_SHIFT-1:0] i_shift,
    output out_t               o_data,
    output logic               o_clip
);

    rq_t w_rq;

    always_comb begin
        w_rq   = requant(i_acc, i_shift);
        o_data = w_rq.val;
        o_clip = w_rq.sat;
    end

endmodule

// File: rtl/pe_dot_accumulator.sv
// Downstream stage of the vec_mul dot-product lane. Accumulates cfg_chunks
// signed partial sums into one result, requantises it and offers it on a
// single-entry valid/ready output register. in_ready feeds vec_mul enable:
// only the last beat of a group waits for output space, so no partial sum
// is ever dropped.
// Ports:
//   clk, rstn               clock, asynchronous active-low reset
//   cfg_chunks, cfg_shift   group length (0 means 1) and requant shift,
//                           captured on the first beat of each group
//   y_in, y_valid, in_ready partial-sum input handshake
//   out_data, out_acc,      requantised result, raw accumulated result,
//   out_sat                 saturation flag (accumulator or requant clip)
//   out_valid, out_ready    result handshake
//   busy                    group in progress or result pending
module pe_dot_accumulator
    import pe_pkg::*;
(
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [W_CNT-1:0]        cfg_chunks,
    input  logic [W_SHIFT-1:0]      cfg_shift,
    input  logic signed [W_Y-1:0]   y_in,
    input  logic                    y_valid,
    output logic                    in_ready,
    output logic signed [W_OUT-1:0] out_data,
    output logic signed [W_ACC-1:0] out_acc,
    output logic                    out_sat,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    busy
);

    // Beat classification; the "state" is carried entirely by r_cnt.
    typedef enum logic {
        BEAT_ACCUM,
        BEAT_LAST
    } beat_kind_t;

    logic [W_CNT-1:0]   r_cnt;
    logic [W_CNT-1:0]   r_n;
    logic [W_SHIFT-1:0] r_shift;
    acc_t               r_acc;
    logic               r_ovf;

    logic               r_out_valid;
    out_t               r_out_data;
    acc_t               r_out_acc;
    logic               r_out_sat;

    logic               w_first;
    logic [W_CNT-1:0]   w_n;
    logic [W_SHIFT-1:0] w_shift;
    beat_kind_t         w_kind;
    logic               w_out_blocked;
    logic               w_accept;
    logic               w_load;
    acc_t               w_y_ext;
    acc_sat_t           w_sum;
    logic               w_ovf;
    out_t               w_rq_data;
    logic               w_rq_clip;

    always_comb begin
        w_first = (r_cnt == '0);
        // On the first beat the live cfg applies; afterwards the captured copy.
        if (w_first) begin
            w_n     = (cfg_chunks == '0) ? W_CNT'(1) : cfg_chunks;
            w_shift = cfg_shift;
        end else begin
            w_n     = r_n;
            w_shift = r_shift;
        end
        w_kind = (r_cnt == w_n - W_CNT'(1)) ? BEAT_LAST : BEAT_ACCUM;

        w_out_blocked = r_out_valid & ~out_ready;
        in_ready      = ~w_out_blocked | (w_kind != BEAT_LAST);
        w_accept      = y_valid & in_ready;
        w_load        = w_accept & (w_kind == BEAT_LAST);

        w_y_ext = {{(W_ACC-W_Y){y_in[W_Y-1]}}, y_in};
        // A fresh group starts from zero with a clean overflow flag.
        w_sum   = sat_add(w_first ? '0 : r_acc, w_y_ext);
        w_ovf   = (w_first ? 1'b0 : r_ovf) | w_sum.ovf;
    end

    pe_requant u_requant (
        .i_acc   (w_sum.val),
        .i_shift (w_shift),
        .o_data  (w_rq_data),
        .o_clip  (w_rq_clip)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt       <= '0;
            r_n         <= W_CNT'(1);
            r_shift     <= '0;
            r_acc       <= '0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_acc   <= '0;
            r_out_sat   <= 1'b0;
        end else begin
            if (w_accept) begin
                if (w_first) begin
                    r_n     <= w_n;
                    r_shift <= cfg_shift;
                end
                if (w_kind == BEAT_LAST) begin
                    r_cnt <= '0;
                    r_acc <= '0;
                    r_ovf <= 1'b0;
                end else begin
                    r_cnt <= r_cnt + W_CNT'(1);
                    r_acc <= w_sum.val;
                    r_ovf <= w_ovf;
                end
            end
            // A load wins over a drain in the same cycle, so back-to-back
            // results flow without a bubble.
            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_rq_data;
                r_out_acc   <= w_sum.val;
                r_out_sat   <= w_ovf | w_rq_clip;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_acc   = r_out_acc;
    assign out_sat   = r_out_sat;
    assign busy      = (r_cnt != '0) | r_out_valid;

endmodule

// File: tb/tb_pe_dot_accumulator.sv
// Directed bench for pe_dot_accumulator; hand-computed expected values.
module tb_pe_dot_accumulator;
    import pe_pkg::*;

    logic                    clk;
    logic                    rstn;
    logic [W_CNT-1:0]        cfg_chunks;
    logic [W_SHIFT-1:0]      cfg_shift;
    logic signed [W_Y-1:0]   y_in;
    logic                    y_valid;
    logic                    in_ready;
    logic signed [W_OUT-1:0] out_data;
    logic signed [W_ACC-1:0] out_acc;
    logic                    out_sat;
    logic                    out_valid;
    logic                    out_ready;
    logic                    busy;

    int errors = 0;
    int checks = 0;
    int got_q[$];

    pe_dot_accumulator dut (
        .clk        (clk),
        .rstn       (rstn),
        .cfg_chunks (cfg_chunks),
        .cfg_shift  (cfg_shift),
        .y_in       (y_in),
        .y_valid    (y_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_acc    (out_acc),
        .out_sat    (out_sat),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Log every output handshake; inputs only move just after rising edges.
    always @(negedge clk) begin
        if (rstn && out_valid && out_ready) got_q.push_back(int'(out_data));
    end

    // Presents one beat and holds it until accepted; returns 1ns after the accepting edge.
    task automatic drive_beat(input int y);
        int guard;
        y_in    = y[W_Y-1:0];
        y_valid = 1'b1;
        #1;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #2;
            guard++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL beat_timeout y=%0d in_ready=%b required=1", y, in_ready);
        end
        @(posedge clk); #1;
        y_valid = 1'b0;
        $display("beat y=%0d accepted t=%0t", y, $time);
    endtask

    task automatic test_reset();
        rstn = 1'b0; y_valid = 1'b0; y_in = '0; cfg_chunks = '0; cfg_shift = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, out_data, out_acc, out_sat, busy, in_ready} !== {1'b0, 16'sd0, 32'sd0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_state got v=%b d=%0d a=%0d s=%b busy=%b rdy=%b required 0,0,0,0,0,1",
                     out_valid, out_data, out_acc, out_sat, busy, in_ready);
        end
        rstn = 1'b1;
        @(posedge clk); #1;
        $display("reset released");
    endtask

    task automatic test_basic();
        cfg_chunks = 9'd3; cfg_shift = 5'd0;
        drive_beat(54);
        drive_beat(54);
        checks++;
        if ({out_valid, busy} !== 2'b01) begin
            errors++; $display("FAIL basic_midgroup got valid=%b busy=%b required valid=0 busy=1", out_valid, busy);
        end
        drive_beat(54);
        // Result visible one cycle after the last beat is accepted.
        checks++;
        if ({out_valid, out_data, out_acc, out_sat} !== {1'b1, 16'sd162, 32'sd162, 1'b0}) begin
            errors++; $display("FAIL basic_result got v=%b d=%0d a=%0d s=%b required 1,162,162,0",
                               out_valid, out_data, out_acc, out_sat);
        end
        @(posedge clk); #1;
        checks++;
        if ({out_valid, busy} !== 2'b00) begin
            errors++; $display("FAIL basic_single got valid=%b busy=%b required 0,0", out_valid, busy);
        end
    endtask

    task automatic test_shift();
        cfg_chunks = 9'd3; cfg_shift = 5'd2;
        drive_beat(54); drive_beat(54); drive_beat(54);
        checks++;
        if ({out_valid, out_data, out_acc, out_sat} !== {1'b1, 16'sd41, 32'sd162, 1'b0}) begin
            errors++; $display("FAIL shift2 got v=%b d=%0d a=%0d s=%b required 1,41,162,0",
                               out_valid, out_data, out_acc, out_sat);
        end
    endtask

    task automatic test_round();
        cfg_chunks = 9'd1; cfg_shift = 5'd1;
        drive_beat(-5);
        checks++;
        if ({out_valid, out_data, out_acc, out_sat} !== {1'b1, -16'sd2, -32'sd5, 1'b0}) begin
            errors++; $display("FAIL round_neg got v=%b d=%0d a=%0d s=%b required 1,-2,-5,0",
                               out_valid, out_data, out_acc, out_sat);
        end
        drive_beat(7);
        checks++;
        if ({out_valid, out_data, out_acc, out_sat} !== {1'b1, 16'sd4, 32'sd7, 1'b0}) begin
            errors++; $display("FAIL round_pos got v=%b d=%0d a=%0d s=%b required 1,4,7,0",
                               out_valid, out_data, out_acc, out_sat);
        end
    endtask

    task automatic test_saturate();
        cfg_chunks = 9'd2; cfg_shift = 5'd0;
        drive_beat(30000); drive_beat(30000);
        checks++;
        if ({out_valid, out_data, out_acc, out_sat} !== {1'b1, 16'sd32767, 32'sd60000, 1'b1}) begin
            errors++; $display("FAIL sat_pos got v=%b d=%0d a=%0d s=%b required 1,32767,60000,1",
                               out_valid, out_data, out_acc, out_sat);
        end
        cfg_chunks = 9'd1;
        drive_beat(-100000);
        checks++;
        if ({out_valid, out_data, out_acc, out_sat} !== {1'b1, 16'h8000, -32'sd100000, 1'b1}) begin
            errors++; $display("FAIL sat_neg got v=%b d=%0d a=%0d s=%b required 1,-32768,-100000,1",
                               out_valid, out_data, out_acc, out_sat);
        end
    endtask

    task automatic test_chunks_zero();
        cfg_chunks = 9'd0; cfg_shift = 5'd0;
        drive_beat(123);
        checks++;
        if ({out_valid, out_data, out_acc, out_sat} !== {1'b1, 16'sd123, 32'sd123, 1'b0}) begin
            errors++; $display("FAIL chunks0_a got v=%b d=%0d a=%0d s=%b required 1,123,123,0",
                               out_valid, out_data, out_acc, out_sat);
        end
        drive_beat(-1);
        checks++;
        if ({out_valid, out_data, out_acc, out_sat} !== {1'b1, -16'sd1, -32'sd1, 1'b0}) begin
            errors++; $display("FAIL chunks0_b got v=%b d=%0d a=%0d s=%b required 1,-1,-1,0",
                               out_valid, out_data, out_acc, out_sat);
        end
    endtask

    task automatic test_cfg_midgroup();
        cfg_chunks = 9'd2; cfg_shift = 5'd0;
        drive_beat(1);
        cfg_chunks = 9'd5; cfg_shift = 5'd3;
        drive_beat(2);
        checks++;
        if ({out_valid, out_data, out_acc, out_sat} !== {1'b1, 16'sd3, 32'sd3, 1'b0}) begin
            errors++; $display("FAIL cfg_midgroup got v=%b d=%0d a=%0d s=%b required 1,3,3,0",
                               out_valid, out_data, out_acc, out_sat);
        end
    endtask

    task automatic test_back_to_back_stall();
        int acc_n;
        int stall;
        int guard;
        logic exp_rdy;
        repeat (2) @(posedge clk);
        #1;
        got_q.delete();
        cfg_chunks = 9'd2; cfg_shift = 5'd0;
        out_ready = 1'b0; y_in = 18'sd10; y_valid = 1'b1;
        acc_n = 0; stall = 0; guard = 0;
        #1;
        while (acc_n < 6 && guard < 40) begin
            guard++;
            exp_rdy = !(acc_n == 3 && !out_ready);
            checks++;
            if (in_ready !== exp_rdy) begin
                errors++; $display("FAIL stall_ready beat=%0d got=%b required=%b", acc_n + 1, in_ready, exp_rdy);
            end
            if (!in_ready) begin
                stall++;
                checks++;
                if ({out_valid, out_data, out_acc, out_sat} !== {1'b1, 16'sd20, 32'sd20, 1'b0}) begin
                    errors++; $display("FAIL stall_hold got v=%b d=%0d a=%0d s=%b required 1,20,20,0",
                                       out_valid, out_data, out_acc, out_sat);
                end
                if (stall == 3) begin
                    out_ready = 1'b1;
                    #1;
                end
            end
            if (in_ready) acc_n++;
            @(posedge clk); #2;
            if (acc_n == 6) y_valid = 1'b0;
        end
        y_valid = 1'b0;
        checks++;
        if (acc_n != 6) begin
            errors++; $display("FAIL stall_timeout got beats=%0d required 6", acc_n);
        end
        checks++;
        if (stall != 3) begin
            errors++; $display("FAIL stall_count got=%0d required 3", stall);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (got_q.size() != 3 || out_valid !== 1'b0) begin
            errors++; $display("FAIL stall_results got count=%0d valid=%b required 3,0", got_q.size(), out_valid);
        end
        foreach (got_q[i]) begin
            checks++;
            if (got_q[i] != 20) begin
                errors++; $display("FAIL stall_result%0d got=%0d required 20", i, got_q[i]);
            end
            $display("stall result %0d = %0d", i, got_q[i]);
        end
    endtask

    task automatic test_reset_midgroup();
        out_ready = 1'b0;
        cfg_chunks = 9'd1; cfg_shift = 5'd0;
        drive_beat(9);
        cfg_chunks = 9'd3;
        drive_beat(5);
        checks++;
        if ({out_valid, busy} !== 2'b11) begin
            errors++; $display("FAIL rst_pre got valid=%b busy=%b required 1,1", out_valid, busy);
        end
        rstn = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_data, out_acc, out_sat, busy, in_ready} !== {1'b0, 16'sd0, 32'sd0, 1'b0, 1'b0, 1'b1}) begin
            errors++; $display("FAIL rst_mid got v=%b d=%0d a=%0d s=%b busy=%b rdy=%b required 0,0,0,0,0,1",
                               out_valid, out_data, out_acc, out_sat, busy, in_ready);
        end
        @(posedge clk); #1;
        rstn = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL rst_release_ready got=%b required 1", in_ready);
        end
        out_ready = 1'b1;
        cfg_chunks = 9'd3; cfg_shift = 5'd0;
        drive_beat(5); drive_beat(5); drive_beat(5);
        checks++;
        if ({out_valid, out_data, out_acc, out_sat} !== {1'b1, 16'sd15, 32'sd15, 1'b0}) begin
            errors++; $display("FAIL rst_after got v=%b d=%0d a=%0d s=%b required 1,15,15,0",
                               out_valid, out_data, out_acc, out_sat);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_shift();
        test_round();
        test_saturate();
        test_chunks_zero();
        test_cfg_midgroup();
        test_back_to_back_stall();
        test_reset_midgroup();
        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
